// File: rtl/data_mem_core_pkg.sv
// Shared definitions for the data memory: access-size encodings, default base address, word width.
// The optional store trace in data_mem_core is enabled with the DM_TRACE_EN macro.
package data_mem_core_pkg;

  localparam int WORD_W = 32;

  localparam logic [31:0] DATA_BASE_ADDRESS = 32'h0000_0000;

  typedef enum logic [1:0] {
    MEM_WORD     = 2'd0,
    MEM_BYTE     = 2'd1,
    MEM_HALF     = 2'd2,
    MEM_WORD_ALT = 2'd3
  } mem_op_e;

  // Halfwords must sit on lane 0 or lane 2.
  function automatic logic half_misaligned(input logic [1:0] mem_op, input logic [1:0] lane);
    return (mem_op == MEM_HALF) && lane[0];
  endfunction

endpackage

// File: rtl/data_mem_core_mem_ext.sv
// Zero- or sign-extends an IN_W-bit load value (byte or halfword) to a full data word.
module mem_ext
  import data_mem_core_pkg::*;
#(
  parameter int IN_W = 8
) (
  input  logic [IN_W-1:0]   din,
  input  logic              sign_ext,
  output logic [WORD_W-1:0] dout
);

  assign dout = {{(WORD_W - IN_W){sign_ext & din[IN_W-1]}}, din};

endmodule

// File: rtl/data_mem_core.sv
// Word-organised data memory with byte/half/word access, combinational loads and negedge stores.
// Optional macro DM_TRACE_EN adds a simulation-only message for every store attempt.
module data_mem_core
  import data_mem_core_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DATA_BASE_ADDRESS,
  parameter int          DEPTH     = 128
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              DMWr,
  input  logic [1:0]        MemOp,
  input  logic              MemEXT,
  input  logic [31:0]       address,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout,
  output logic              align_err
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];

  logic [31:0]       offset;
  logic [IDX_W-1:0]  index;
  logic [1:0]        lane;
  logic              is_byte;
  logic              is_half;
  logic [WORD_W-1:0] rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [WORD_W-1:0] byte_ext_word;
  logic [WORD_W-1:0] half_ext_word;
  logic [WORD_W-1:0] wr_word;
  logic              wr_en;
  logic              unused_offset_hi;

  // Offset bits above the index are deliberately dropped so the address space wraps.
  assign offset           = address - BASE_ADDR;
  assign index            = offset[IDX_W+1:2];
  assign lane             = offset[1:0];
  assign unused_offset_hi = ^offset[31:IDX_W+2];

  assign is_byte   = (MemOp == MEM_BYTE);
  assign is_half   = (MemOp == MEM_HALF);
  assign align_err = half_misaligned(MemOp, lane);

  assign rd_word = mem[index];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  mem_ext #(.IN_W(8)) u_byte_ext (
    .din      (rd_byte),
    .sign_ext (MemEXT),
    .dout     (byte_ext_word)
  );

  mem_ext #(.IN_W(16)) u_half_ext (
    .din      (rd_half),
    .sign_ext (MemEXT),
    .dout     (half_ext_word)
  );

  // Load path: reserved MemOp encoding falls through to a plain word load.
  always_comb begin
    dout = rd_word;
    if (is_byte) begin
      dout = byte_ext_word;
    end else if (is_half) begin
      dout = align_err ? '0 : half_ext_word;
    end
  end

  // Store merge: only the addressed lane(s) of the current word are replaced.
  always_comb begin
    wr_word = rd_word;
    if (is_byte) begin
      wr_word[{lane, 3'b000} +: 8] = din[7:0];
    end else if (is_half) begin
      if (lane[1]) begin
        wr_word[31:16] = din[15:0];
      end else begin
        wr_word[15:0] = din[15:0];
      end
    end else begin
      wr_word = din;
    end
  end

  assign wr_en = DMWr & ~align_err;

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[index] <= wr_word;
    end
  end

`ifdef DM_TRACE_EN
  always @(negedge clk) begin
    if (rstn && DMWr) begin
      if (align_err) begin
        $display("store half, wrong boundary!");
      end else if (is_byte) begin
        $display("store byte: offset=0x%08h index=%0d word=0x%08h byte=0x%02h lane=%0d",
                 offset, index, wr_word, din[7:0], lane);
      end else if (is_half) begin
        $display("store half: offset=0x%08h index=%0d word=0x%08h half=0x%04h lane=%0d",
                 offset, index, wr_word, din[15:0], lane);
      end else begin
        $display("store word: offset=0x%08h index=%0d word=0x%08h",
                 offset, index, wr_word);
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_core.sv
// Directed self-checking bench for data_mem_core: reset, word/byte/half access, misalignment, wrap, timing.
module tb_data_mem_core;
  import data_mem_core_pkg::*;

  logic        clk;
  logic        rstn;
  logic        DMWr;
  logic [1:0]  MemOp;
  logic        MemEXT;
  logic [31:0] address;
  logic [31:0] din;
  logic [31:0] dout;
  logic        align_err;

  int total;
  int bad;

  data_mem_core dut (
    .clk       (clk),
    .rstn      (rstn),
    .DMWr      (DMWr),
    .MemOp     (MemOp),
    .MemEXT    (MemEXT),
    .address   (address),
    .din       (din),
    .dout      (dout),
    .align_err (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change 1 ns after the posedge, leaving half a cycle before the store edge.
  task automatic applyStimulus(input logic we, input logic [1:0] op, input logic ext,
                               input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk);
    #1;
    DMWr    = we;
    MemOp   = op;
    MemEXT  = ext;
    address = addr;
    din     = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] exp_dout, input logic exp_err);
    total++;
    assert (dout === exp_dout) else begin
      bad++;
      $error("[TB] FAIL %s dout: got 0x%08h expected 0x%08h", tag, dout, exp_dout);
    end
    total++;
    assert (align_err === exp_err) else begin
      bad++;
      $error("[TB] FAIL %s align_err: got %0b expected %0b", tag, align_err, exp_err);
    end
  endtask

  task automatic storeOp(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, op, 1'b0, addr, data);
    @(negedge clk);
    #1;
    DMWr = 1'b0;
  endtask

  task automatic loadCheck(input string tag, input logic [1:0] op, input logic ext,
                           input logic [31:0] addr, input logic [31:0] exp_dout, input logic exp_err);
    applyStimulus(1'b0, op, ext, addr, 32'h0);
    #1;
    checkOutput(tag, exp_dout, exp_err);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rstn    = 1'b1;
    DMWr    = 1'b0;
    MemOp   = MEM_WORD;
    MemEXT  = 1'b0;
    address = 32'h0;
    din     = 32'h0;

    #2 rstn = 1'b0;
    #2 checkOutput("reset_during", 32'h0, 1'b0);
    #4 rstn = 1'b1;

    loadCheck("reset_w00",  MEM_WORD, 1'b0, 32'h0000_0000, 32'h0, 1'b0);
    loadCheck("reset_w7c",  MEM_WORD, 1'b0, 32'h0000_007C, 32'h0, 1'b0);
    loadCheck("reset_w1fc", MEM_WORD, 1'b0, 32'h0000_01FC, 32'h0, 1'b0);

    storeOp(MEM_WORD, 32'h0000_007C, 32'hCAFE_F00D);
    loadCheck("pre_reset_w7c", MEM_WORD, 1'b0, 32'h0000_007C, 32'hCAFE_F00D, 1'b0);

    // A store is pending when reset pulses across its negedge; reset must win.
    applyStimulus(1'b1, MEM_WORD, 1'b0, 32'h0000_0008, 32'h1234_5678);
    #3 rstn = 1'b0;
    #3 rstn = 1'b1;
    DMWr = 1'b0;
    #1 checkOutput("reset_store_w08", 32'h0, 1'b0);
    loadCheck("reset_clr_w7c", MEM_WORD, 1'b0, 32'h0000_007C, 32'h0, 1'b0);

    storeOp(MEM_WORD, 32'h0000_0008, 32'h1234_ABCD);
    loadCheck("word_w08", MEM_WORD, 1'b0, 32'h0000_0008, 32'h1234_ABCD, 1'b0);
    loadCheck("word_w0a", MEM_WORD, 1'b1, 32'h0000_000A, 32'h1234_ABCD, 1'b0);

    storeOp(MEM_WORD, 32'h0000_0010, 32'h0);
    storeOp(MEM_BYTE, 32'h0000_0011, 32'hFFFF_FF80);
    storeOp(MEM_BYTE, 32'h0000_0013, 32'h0000_007F);
    loadCheck("byte_word10",  MEM_WORD, 1'b0, 32'h0000_0010, 32'h7F00_8000, 1'b0);
    loadCheck("byte_s11",     MEM_BYTE, 1'b1, 32'h0000_0011, 32'hFFFF_FF80, 1'b0);
    loadCheck("byte_u11",     MEM_BYTE, 1'b0, 32'h0000_0011, 32'h0000_0080, 1'b0);
    loadCheck("byte_s13",     MEM_BYTE, 1'b1, 32'h0000_0013, 32'h0000_007F, 1'b0);
    loadCheck("byte_s12",     MEM_BYTE, 1'b1, 32'h0000_0012, 32'h0000_0000, 1'b0);

    storeOp(MEM_WORD, 32'h0000_0020, 32'h1111_2222);
    storeOp(MEM_HALF, 32'h0000_0022, 32'hAAAA_BEEF);
    loadCheck("half_word20", MEM_WORD, 1'b0, 32'h0000_0020, 32'hBEEF_2222, 1'b0);
    loadCheck("half_s22",    MEM_HALF, 1'b1, 32'h0000_0022, 32'hFFFF_BEEF, 1'b0);
    loadCheck("half_u22",    MEM_HALF, 1'b0, 32'h0000_0022, 32'h0000_BEEF, 1'b0);
    loadCheck("half_s20",    MEM_HALF, 1'b1, 32'h0000_0020, 32'h0000_2222, 1'b0);

    applyStimulus(1'b1, MEM_HALF, 1'b0, 32'h0000_0021, 32'h0000_5555);
    #1 checkOutput("misal_store21", 32'h0, 1'b1);
    @(negedge clk);
    #1 DMWr = 1'b0;
    loadCheck("misal_word20", MEM_WORD, 1'b0, 32'h0000_0020, 32'hBEEF_2222, 1'b0);
    loadCheck("misal_load21", MEM_HALF, 1'b1, 32'h0000_0021, 32'h0, 1'b1);
    loadCheck("misal_load23", MEM_HALF, 1'b0, 32'h0000_0023, 32'h0, 1'b1);

    storeOp(MEM_WORD, 32'h0000_0200, 32'hA5A5_0001);
    loadCheck("wrap_w000", MEM_WORD, 1'b0, 32'h0000_0000, 32'hA5A5_0001, 1'b0);
    loadCheck("wrap_w200", MEM_WORD, 1'b0, 32'h0000_0200, 32'hA5A5_0001, 1'b0);

    // dout must hold the old word through the posedge half and update only after the negedge.
    applyStimulus(1'b1, MEM_WORD, 1'b0, 32'h0000_0008, 32'h0BAD_F00D);
    #1 checkOutput("timing_early", 32'h1234_ABCD, 1'b0);
    #2 checkOutput("timing_late",  32'h1234_ABCD, 1'b0);
    @(negedge clk);
    #1 checkOutput("timing_after", 32'h0BAD_F00D, 1'b0);
    DMWr = 1'b0;

    loadCheck("op3_word08", MEM_WORD_ALT, 1'b1, 32'h0000_0009, 32'h0BAD_F00D, 1'b0);
    storeOp(MEM_WORD_ALT, 32'h0000_0011, 32'hDEAD_BEEF);
    loadCheck("op3_store10", MEM_WORD, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_core.md
Name: data_mem_core

Overview:
- Word-organised data memory for the multi-cycle CPU datapath.
- Supports byte, halfword and word loads and stores, with zero- or sign-extension of sub-word loads.
- Reads are combinational; writes commit on the falling clock edge so the CPU can set up address and data in the first half-cycle.
- Sits between the ALU address output and the register write-back mux.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0; subtracted from `address` before indexing.
- DEPTH, 128, number of 32-bit words; the index is log2(DEPTH) bits wide (7 by default).

Ports:
- clk  in  1  system clock; stores commit on the negedge.
- rstn  in  1  asynchronous active-low reset.
- DMWr  in  1  1 = store this cycle, 0 = read only.
- MemOp  in  2  access size: 2'd0 word, 2'd1 byte, 2'd2 half; 2'd3 is treated as word.
- MemEXT  in  1  load extension: 0 = zero-extend, 1 = sign-extend.
- address  in  32  byte address.
- din  in  32  store data; low 8 or 16 bits are used for byte or half.
- dout  out  32  load data, combinational.
- align_err  out  1  combinational; 1 when MemOp = half and offset[0] = 1.

Behaviour:
- Address decode:
  - offset = address − BASE_ADDR, modulo 2^32.
  - index = offset[8:2] (log2(DEPTH)+1 : 2); higher offset bits are ignored, so addresses wrap modulo DEPTH*4 bytes.
  - lane = offset[1:0].
- Byte lanes are little-endian: lane 0 = bits [7:0], lane 3 = bits [31:24].
- Reset: while rstn = 0, all DEPTH words are cleared to 0 asynchronously and no store occurs. dout reflects the cleared memory combinationally.
- Loads, combinational from mem[index]:
  - Byte: selected lane byte, extended to 32 bits.
  - Half: lane 0 → [15:0], lane 2 → [31:16], extended to 32 bits.
  - Word: mem[index] unchanged; lane bits are ignored and MemEXT has no effect.
  - Sign-extension replicates bit 7 (byte) or bit 15 (half).
- Misaligned half (lane 1 or 3): dout = 0 and align_err = 1.
- Stores, on negedge clk when DMWr = 1 and rstn = 1 (read-modify-write of mem[index]):
  - Byte: replace only the addressed lane with din[7:0].
  - Half: lane 0 → [15:0], lane 2 → [31:16], from din[15:0].
  - Word: replace the full word with din; lane bits are ignored.
  - Misaligned half store is suppressed; memory is unchanged.
- Loading the same word after a store completes returns the new value immediately; there is no read latency.
- Reset asserted on the same negedge as a store: reset wins and memory is 0.
- `dout` during a store cycle shows the pre-write content until the negedge, then the new content.

Optional Feature:
- DM_TRACE_EN:
  - Defined: on each committed or suppressed store, print a simulation-only message.
    - Committed store: access size, offset, index, resulting word in hex, and the written byte or half with its lane.
    - Misaligned half store: "store half, wrong boundary!".
  - Undefined: no $display code; functionally identical.

Decomposition:
- Shared package holds:
  - MEM_WORD/MEM_BYTE/MEM_HALF MemOp encodings.
  - DATA_BASE_ADDRESS default.
  - Word width constant.
- One natural sub-module, mem_ext:
  - Parameterised input width (8 or 16).
  - Zero- or sign-extends to 32 bits under an extension-select input.
  - Instantiated twice, once for byte and once for half.
- The storage array and lane merge stay in the top module.

Test Plan:
- Reset: pulse rstn low for 3 ns mid-cycle → word loads at offsets 0x00, 0x7C and 0x1FC all read 0; a store issued during reset leaves memory 0.
- Word store/load: store 0x1234_ABCD at offset 0x08 → word load = 0x1234ABCD; load at offset 0x0A with MemOp word also = 0x1234ABCD.
- Byte stores/loads:
  - Setup: clear word at offset 0x10 to 0, then store byte 0x80 at offset 0x11 and byte 0x7F at 0x13.
  - Word load = 0x7F008000.
  - Byte load at 0x11: signed → 0xFFFFFF80, zero-extended → 0x00000080.
- Half stores/loads:
  - Store half 0xBEEF at offset 0x22 over existing word 0x11112222 → word = 0xBEEF2222.
  - Half load at 0x22: signed → 0xFFFFBEEF, unsigned → 0x0000BEEF.
- Misaligned half: store half 0x5555 at offset 0x21 → align_err = 1, word unchanged at 0xBEEF2222, half load at 0x21 returns dout = 0.
- Wrap and timing:
  - Store at offset 0x200 → lands in index 0.
  - dout changes only after the negedge, not at the posedge.
